// File: rtl/mips_isa_pkg.sv
// Shared MIPS subset definitions: opcodes, funct codes, record kinds, error codes and the
// loader FSM state type. Also used by the control decoder, so keep the encodings aligned with it.
package mips_isa_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;

    // R-type funct codes
    localparam logic [5:0] FN_ADDU = 6'd33;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_SLT  = 6'd42;

    // Symbolic record kinds; 9-15 are illegal
    localparam logic [3:0] KIND_ADDU = 4'd0;
    localparam logic [3:0] KIND_SUB  = 4'd1;
    localparam logic [3:0] KIND_AND  = 4'd2;
    localparam logic [3:0] KIND_OR   = 4'd3;
    localparam logic [3:0] KIND_SLT  = 4'd4;
    localparam logic [3:0] KIND_LW   = 4'd5;
    localparam logic [3:0] KIND_SW   = 4'd6;
    localparam logic [3:0] KIND_BEQ  = 4'd7;
    localparam logic [3:0] KIND_NOP  = 4'd8;

    // Sticky error codes
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone,
        StErr
    } enc_state_e;

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Record input stream, imem write port and status of the instruction encoder.
// master = loader/test side, slave = encoder.
interface mips_instr_encoder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic [1:0]        err;
    logic [ADDR_W:0]   count;

    modport master (
        output start, in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count
    );

    modport slave (
        input  start, in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count
    );

endinterface

// File: rtl/mips_field_pack.sv
// Combinational packer: symbolic record (kind + register/immediate fields) -> 32-bit MIPS word.
// legal is low for kinds outside the supported subset; word is then zero and must not be written.
module mips_field_pack
    import mips_isa_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    // Select opcode/funct by kind and assemble the fields; unused fields are dropped
    always_comb begin
        word  = 32'h0;
        legal = 1'b1;
        case (kind)
            KIND_ADDU: word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADDU};
            KIND_SUB:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
            KIND_AND:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
            KIND_OR:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
            KIND_SLT:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
            KIND_LW:   word = {OP_LW, rs, rt, imm};
            KIND_SW:   word = {OP_SW, rs, rt, imm};
            KIND_BEQ:  word = {OP_BEQ, rs, rt, imm};
            KIND_NOP:  word = 32'h0;
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Boot/test loader writer: accepts symbolic instruction records, encodes them and writes them
// to consecutive imem word addresses starting at BASE_ADDR. One write per accepted record,
// registered one cycle after the accept.
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 256
) (
    input logic                clk,
    input logic                reset,
    mips_instr_encoder_if.slave bus
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W + 1)'(1);

    enc_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        err_q, err_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic [31:0] packed_word;
    logic        legal;
    logic        accept;

    mips_field_pack u_pack (
        .kind  (bus.in_kind),
        .rs    (bus.in_rs),
        .rt    (bus.in_rt),
        .rd    (bus.in_rd),
        .imm   (bus.in_imm),
        .word  (packed_word),
        .legal (legal)
    );

    assign accept = bus.in_valid && (state_q == StRun);

    // Next-state: start handling, record accept, error detection and write scheduling
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        count_d = count_q;
        unique case (state_q)
            StIdle, StErr: begin
                if (bus.start) begin
                    state_d = StRun;
                    err_d   = ERR_NONE;
                    count_d = '0;
                    addr_d  = BASE_C;
                end
            end
            StDone: begin
                if (bus.start) begin
                    state_d = StRun;
                    err_d   = ERR_NONE;
                    count_d = '0;
                    addr_d  = BASE_C;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (accept) begin
                    // Illegal kind takes priority over overflow
                    if (!legal) begin
                        err_d   = ERR_ILLEGAL;
                        state_d = StErr;
                    end else if (count_q == DEPTH_C) begin
                        err_d   = ERR_OVERFLOW;
                        state_d = StErr;
                    end else begin
                        we_d    = 1'b1;
                        // BASE_ADDR + DEPTH fits the address space, so truncation is safe
                        addr_d  = BASE_C + count_q[ADDR_W-1:0];
                        wdata_d = packed_word;
                        count_d = count_q + ONE_C;
                        if (bus.in_last) begin
                            state_d = StDone;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; synchronous reset also drops any pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= BASE_C;
            wdata_q <= 32'h0;
            err_q   <= ERR_NONE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready   = (state_q == StRun);
    assign bus.busy       = (state_q == StRun);
    assign bus.done       = (state_q == StDone);
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.err        = err_q;
    assign bus.count      = count_q;

endmodule
